apb_regbank_slave: RTL
======================

# apb_regbank_slave

APB completer that terminates the bus driven by the verification master agent and serves as the register-bank DUT. It decodes a 32-bit byte address onto two word-addressed 32-bit banks: bank0 at word indices 0..511, bank1 at 512..767. Bank-dependent wait states are inserted on `pready`. Illegal accesses are flagged with a single-cycle `pslverr`.

## Interface
- `BANK0_DEPTH`, 512: bank0 words, at word index 0..BANK0_DEPTH-1
- `BANK1_DEPTH`, 256: bank1 words, at word index BANK0_DEPTH..BANK0_DEPTH+BANK1_DEPTH-1
- `BANK0_WAIT`, 0: wait cycles inserted before `pready` for bank0 (0..15)
- `BANK1_WAIT`, 2: wait cycles inserted before `pready` for bank1 (0..15)
- `pclk`  in  1  bus clock; all logic on rising edge
- `preset_n`  in  1  asynchronous active-low reset
- `psel`  in  1  completer select
- `penable`  in  1  access phase strobe
- `pwrite`  in  1  1 = write, 0 = read
- `paddr`  in  32  byte address; word index = `paddr[31:2]`
- `pwdata`  in  32  write data
- `prdata`  out  32  read data, valid while `pready`=1 on a read
- `pready`  out  1  transfer-complete strobe
- `pslverr`  out  1  error response, valid only while `pready`=1
- `prot_err`  out  1  one-cycle pulse on a protocol violation

## Operation
- FSM states:
  - IDLE: default state.
  - ACCESS: transfer in progress.
- IDLE→ACCESS on an edge that samples `psel`=1, `penable`=0 (setup phase).
  - At that edge, latch `paddr`, `pwrite`, `pwdata` and the decode result.
  - Load `wait_cnt` = the bank's WAIT value, or 0 if the access is illegal.
  - Set `pready` <= (`wait_cnt` load == 0).
- ACCESS with `pready`=0 and `psel`&`penable`=1:
  - `wait_cnt` <= `wait_cnt`-1.
  - `pready` <= (`wait_cnt`==1).
- ACCESS with `pready`=1 and `psel`&`penable`=1 (completion edge):
  - A legal write commits `pwdata` to the bank here, and only here.
  - `pready` and `pslverr` <= 0; FSM → IDLE.
- Read data and `pslverr` are loaded at the same edge that raises `pready`. `prdata` = mem[index] for a legal read, 32'h0 on an error or a write.
- Illegal access. Both cases give zero waits, `pslverr`=1 with `pready`, no memory update, `prdata`=0:
  - word index ≥ BANK0_DEPTH+BANK1_DEPTH;
  - `paddr[1:0]` ≠ 0.
- Abort: `psel` sampled 0 while in ACCESS → IDLE, `pready`/`pslverr` cleared, no write.
- `prot_err` pulses for 1 cycle on any of:
  - `penable`=1 sampled with FSM in IDLE;
  - `paddr` or `pwrite` differing from the latched value during ACCESS.
  - The transfer continues using the latched values.
- Memory contents are not reset. Reads before any write return X.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, `prot_err`=0, FSM=IDLE, `wait_cnt`=0.
- `preset_n` assertion mid-transfer aborts immediately. A pending write is discarded.
- Zero-wait transfer: `pready`=1 in the first access cycle. Total 2 cycles per transfer.
- N-wait transfer: `pready` rises after N access cycles. Total N+2 cycles.
- `pslverr` is high for exactly one cycle and never without `pready`.
- Back-to-back: a setup phase in the cycle right after completion is accepted with no idle gap.
- Read-after-write to the same word in the next transfer returns the new data.
- `prdata` holds its last value while `pready`=0.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `prot_err` never pulses.
- Write 32'hDEAD_BEEF to `paddr` 32'h0000_0010 (bank0), then read it back → `pready` high in the first access cycle, read returns 32'hDEAD_BEEF, `pslverr`=0.
- Write 32'h1234_5678 to `paddr` 32'h0000_0800 (index 512, bank1), then read it back → `pready` low for 2 access cycles then high for 1, read returns 32'h1234_5678.
- Read `paddr` 32'h0000_0C00 (index 768) and write `paddr` 32'h0000_0013 (unaligned) → each completes in 2 cycles with `pslverr`=1 for 1 cycle, `prdata`=0, memory unchanged on read-back.
- Bank1 write with `psel` dropped after 1 wait cycle → no `pready`, target word unchanged. Then `penable`=1 driven without setup → `prot_err` pulses once.
- Assert `preset_n`=0 during a bank1 write wait state → outputs return to reset values at once, word unchanged. The next legal transfer completes normally.

Source files
------------

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB completer with two word-addressed banks, per-bank wait states and slave error.
// Decode happens at the setup edge; the write is committed only at the completion edge.
module apb_regbank_slave #(
  parameter int BANK0_DEPTH = 512,
  parameter int BANK1_DEPTH = 256,
  parameter int BANK0_WAIT  = 0,
  parameter int BANK1_WAIT  = 2
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        prot_err
);
  localparam int DEPTH = BANK0_DEPTH + BANK1_DEPTH;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, prdata_q, prdata_d;
  logic write_q, write_d, err_q, err_d, pready_q, pready_d, pslverr_q, pslverr_d, prot_q, prot_d;
  logic [3:0] wait_q, wait_d, in_wait;
  logic in_err, do_write;
  logic [AW-1:0] in_idx, q_idx;
  logic [31:0] mem [DEPTH];
  assign in_err = ({2'b0, paddr[31:2]} >= 32'(DEPTH)) || (paddr[1:0] != 2'b0);
  assign in_wait = in_err ? 4'd0 : ({2'b0, paddr[31:2]} < 32'(BANK0_DEPTH)) ? 4'(BANK0_WAIT) : 4'(BANK1_WAIT);
  assign in_idx = paddr[AW+1:2];
  assign q_idx = addr_q[AW+1:2];
  assign do_write = (state_q == ACCESS) && psel && penable && pready_q && write_q && !err_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    err_d = err_q;
    wait_d = wait_q;
    pready_d = pready_q;
    pslverr_d = pslverr_q;
    prdata_d = prdata_q;
    prot_d = 1'b0;
    if (state_q == IDLE) begin
      prot_d = penable;
      if (psel && !penable) begin
        state_d = ACCESS;
        addr_d = paddr;
        write_d = pwrite;
        wdata_d = pwdata;
        err_d = in_err;
        wait_d = in_wait;
        pready_d = (in_wait == 4'd0);
        if (in_wait == 4'd0) begin
          pslverr_d = in_err;
          prdata_d = (!in_err && !pwrite) ? mem[in_idx] : 32'h0;
        end
      end
    end else if (!psel) begin
      state_d = IDLE;
      pready_d = 1'b0;
      pslverr_d = 1'b0;
    end else begin
      // mid-transfer changes are flagged but the latched copy keeps driving the access
      prot_d = (paddr != addr_q) || (pwrite != write_q);
      if (penable && pready_q) begin
        state_d = IDLE;
        pready_d = 1'b0;
        pslverr_d = 1'b0;
      end else if (penable) begin
        wait_d = wait_q - 4'd1;
        pready_d = (wait_q == 4'd1);
        if (wait_q == 4'd1) begin
          pslverr_d = err_q;
          prdata_d = (!err_q && !write_q) ? mem[q_idx] : 32'h0;
        end
      end
    end
  end
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q <= 1'b0;
      wait_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
      prot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      wait_q <= wait_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q <= prdata_d;
      prot_q <= prot_d;
    end
  end
  always_ff @(posedge pclk) begin
    if (do_write) mem[q_idx] <= wdata_q;
  end
  assign prdata = prdata_q;
  assign pready = pready_q;
  assign pslverr = pslverr_q;
  assign prot_err = prot_q;
endmodule
